// File: rtl/systolic_input_ctrl.sv
// Activation input buffer / PE array sequencer: stream K vectors, flush the lane skew, drain, pulse done.
// Optional performance counters are enabled with the SYSTOLIC_CTRL_PERF_EN macro.
module systolic_input_ctrl #(
  parameter int ARRAY_W      = 8,
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] k_len_i,
  input  logic             act_valid_i,
  output logic             act_ready_o,
  output logic             load_en_o,
  output logic             out_en_o,
  output logic             zero_pad_o,
  output logic             arr_en_o,
  output logic             busy_o,
  output logic             done_o
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      tile_cyc_o
`endif
);

  // One counter serves the vector count, the skew flush and the drain.
  localparam int FD_W = $clog2(ARRAY_W + DRAIN_CYCLES);
  localparam int CW   = (CNT_W > FD_W) ? CNT_W : FD_W;
  localparam logic [CW-1:0] FLUSH_LAST = CW'(ARRAY_W - 2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] klen_q, klen_d;
  logic [CNT_W-1:0] klen_m1;
  logic             done_q;
  logic             beat;

  function automatic state_e after_stream();
    if (ARRAY_W > 1)       return S_FLUSH;
    if (DRAIN_CYCLES > 0)  return S_DRAIN;
    return S_DONE;
  endfunction

  assign klen_m1 = klen_q - CNT_W'(1);
  assign beat    = act_valid_i & (state_q == S_STREAM);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    klen_d      = klen_q;
    act_ready_o = 1'b0;
    load_en_o   = 1'b0;
    out_en_o    = 1'b0;
    arr_en_o    = 1'b0;
    zero_pad_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          klen_d = k_len_i;
          cnt_d  = '0;
          state_d = (k_len_i != '0) ? S_STREAM : S_DONE;
        end
      end
      S_STREAM: begin
        act_ready_o = 1'b1;
        if (beat) begin
          load_en_o = 1'b1;
          out_en_o  = 1'b1;
          arr_en_o  = 1'b1;
          if (cnt_q == CW'(klen_m1)) begin
            cnt_d   = '0;
            state_d = after_stream();
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_FLUSH: begin
        load_en_o  = 1'b1;
        out_en_o   = 1'b1;
        arr_en_o   = 1'b1;
        zero_pad_o = 1'b1;
        if (cnt_q == FLUSH_LAST) begin
          cnt_d   = '0;
          state_d = (DRAIN_CYCLES > 0) ? S_DRAIN : S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        load_en_o  = 1'b1;
        out_en_o   = 1'b1;
        arr_en_o   = 1'b1;
        zero_pad_o = 1'b1;
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides every transition; a beat in this cycle is still consumed above.
    if (abort_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      klen_d  = klen_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      klen_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      klen_q  <= klen_d;
      done_q  <= (state_d == S_DONE);
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] tcyc_q, tcyc_d;
  logic        start_acc;

  assign start_acc = (state_q == S_IDLE) & start_i & ~abort_i;

  always_comb begin
    stall_d = stall_q;
    tcyc_d  = tcyc_q;
    if (start_acc) begin
      stall_d = '0;
      tcyc_d  = '0;
    end else begin
      if ((state_q == S_STREAM) && !act_valid_i && (stall_q != 32'hFFFF_FFFF))
        stall_d = stall_q + 32'd1;
      if ((state_q != S_IDLE) && (tcyc_q != 32'hFFFF_FFFF))
        tcyc_d = tcyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
      tcyc_q  <= '0;
    end else begin
      stall_q <= stall_d;
      tcyc_q  <= tcyc_d;
    end
  end

  assign stall_cnt_o = stall_q;
  assign tile_cyc_o  = tcyc_q;
`endif

endmodule

// File: tb/tb_systolic_input_ctrl.sv
// Directed bench for systolic_input_ctrl: a 4-lane/2-drain instance and a 1-lane/0-drain instance.
module tb_systolic_input_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, abort, act_valid;
  logic [15:0] k_len;
  logic        act_ready, load_en, out_en, zero_pad, arr_en, busy, done;
  logic        start1, abort1, act_valid1;
  logic [15:0] k_len1;
  logic        act_ready1, load_en1, out_en1, zero_pad1, arr_en1, busy1, done1;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] stall_cnt, tile_cyc, stall_cnt1, tile_cyc1;
`endif

  int checks = 0;
  int errors = 0;

  // {act_ready, load_en, out_en, arr_en, zero_pad, busy, done}
  wire [6:0] obs  = {act_ready, load_en, out_en, arr_en, zero_pad, busy, done};
  wire [6:0] obs1 = {act_ready1, load_en1, out_en1, arr_en1, zero_pad1, busy1, done1};

  systolic_input_ctrl #(.ARRAY_W(4), .CNT_W(16), .DRAIN_CYCLES(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .k_len_i(k_len),
    .act_valid_i(act_valid), .act_ready_o(act_ready), .load_en_o(load_en), .out_en_o(out_en),
    .zero_pad_o(zero_pad), .arr_en_o(arr_en), .busy_o(busy), .done_o(done)
`ifdef SYSTOLIC_CTRL_PERF_EN
    , .stall_cnt_o(stall_cnt), .tile_cyc_o(tile_cyc)
`endif
  );

  systolic_input_ctrl #(.ARRAY_W(1), .CNT_W(16), .DRAIN_CYCLES(0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .abort_i(abort1), .k_len_i(k_len1),
    .act_valid_i(act_valid1), .act_ready_o(act_ready1), .load_en_o(load_en1), .out_en_o(out_en1),
    .zero_pad_o(zero_pad1), .arr_en_o(arr_en1), .busy_o(busy1), .done_o(done1)
`ifdef SYSTOLIC_CTRL_PERF_EN
    , .stall_cnt_o(stall_cnt1), .tile_cyc_o(tile_cyc1)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (obs !== 7'b0) begin
      errors++; $display("FAIL reset_outputs got %b want %b", obs, 7'b0);
    end
    checks++;
    if (obs1 !== 7'b0) begin
      errors++; $display("FAIL reset_outputs1 got %b want %b", obs1, 7'b0);
    end
    step(); step();
    rst_n = 1'b1;
    act_valid = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b0) begin
      errors++; $display("FAIL reset_release_idle got %b want %b", obs, 7'b0);
    end
    act_valid = 1'b0;
    step();
  endtask

  task automatic test_stream();
    logic [6:0] exp;
    start = 1'b1; k_len = 16'd5; act_valid = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b0) begin
      errors++; $display("FAIL stream_c0 got %b want %b", obs, 7'b0);
    end
    step();
    start = 1'b0; k_len = 16'd0;
    for (int c = 1; c <= 12; c++) begin
      #1;
      exp = {c <= 5, c <= 10, c <= 10, c <= 10, (c >= 6) && (c <= 10), c <= 11, c == 11};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL stream_c%0d got %b want %b", c, obs, exp);
      end
      step();
    end
`ifdef SYSTOLIC_CTRL_PERF_EN
    checks++;
    if (tile_cyc !== 32'd11 || stall_cnt !== 32'd0) begin
      errors++; $display("FAIL stream_perf got tile=%0d stall=%0d want 11 0", tile_cyc, stall_cnt);
    end
`endif
    act_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic [0:6] pat = 7'b1001101;
    logic [6:0] exp;
    start = 1'b1; k_len = 16'd4; act_valid = 1'b0;
    step();
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      act_valid = (c <= 7) ? pat[c-1] : 1'b0;
      #1;
      if (c <= 7)       exp = {1'b1, pat[c-1], pat[c-1], pat[c-1], 1'b0, 1'b1, 1'b0};
      else if (c <= 12) exp = 7'b0111110;
      else if (c == 13) exp = 7'b0000011;
      else              exp = 7'b0000000;
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL stall_c%0d got %b want %b", c, obs, exp);
      end
      step();
    end
`ifdef SYSTOLIC_CTRL_PERF_EN
    checks++;
    if (stall_cnt !== 32'd3 || tile_cyc !== 32'd13) begin
      errors++; $display("FAIL stall_perf got stall=%0d tile=%0d want 3 13", stall_cnt, tile_cyc);
    end
`endif
    act_valid = 1'b0;
  endtask

  task automatic test_zero_len();
    start = 1'b1; k_len = 16'd0; act_valid = 1'b1;
    step();
    start = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b0000011) begin
      errors++; $display("FAIL zero_len_c1 got %b want %b", obs, 7'b0000011);
    end
    step();
    checks++;
    if (obs !== 7'b0000000) begin
      errors++; $display("FAIL zero_len_c2 got %b want %b", obs, 7'b0000000);
    end
    step();
    act_valid = 1'b0;
  endtask

  task automatic test_abort();
    logic [6:0] exp;
    int ndone, first;
    start = 1'b1; k_len = 16'd2; act_valid = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      abort = (c == 4);
      #1;
      if (c <= 2)      exp = 7'b1111010;
      else if (c <= 4) exp = 7'b0111110;
      else             exp = 7'b0000000;
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL abort_flush_c%0d got %b want %b", c, obs, exp);
      end
      step();
    end
    abort = 1'b0;
    // abort during a beat: beat consumed, ready drops next cycle
    start = 1'b1; k_len = 16'd5;
    step();
    start = 1'b0; abort = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b1111010) begin
      errors++; $display("FAIL abort_beat got %b want %b", obs, 7'b1111010);
    end
    step();
    abort = 1'b0;
    checks++;
    if (obs !== 7'b0000000) begin
      errors++; $display("FAIL abort_beat_next got %b want %b", obs, 7'b0000000);
    end
    // abort and start together in IDLE
    start = 1'b1; abort = 1'b1; k_len = 16'd3;
    step();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (obs !== 7'b0000000) begin
      errors++; $display("FAIL abort_start_idle got %b want %b", obs, 7'b0000000);
    end
    start = 1'b1; k_len = 16'd3;
    step();
    start = 1'b0;
    ndone = 0; first = -1;
    for (int c = 1; c <= 20; c++) begin
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = c;
      end
      step();
    end
    checks++;
    if (first != 9 || ndone != 1) begin
      errors++; $display("FAIL abort_recover got done_cycle=%0d count=%0d want 9 1", first, ndone);
    end
    act_valid = 1'b0;
  endtask

  task automatic test_busy_start_reset();
    int ndone, first;
    start = 1'b1; k_len = 16'd3; act_valid = 1'b1;
    step();
    start = 1'b0;
    ndone = 0; first = -1;
    for (int c = 1; c <= 14; c++) begin
      if (c == 2) begin start = 1'b1; k_len = 16'd7; end
      else begin start = 1'b0; end
      #1;
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = c;
      end
      step();
    end
    start = 1'b0;
    checks++;
    if (first != 9 || ndone != 1) begin
      errors++; $display("FAIL start_while_busy got done_cycle=%0d count=%0d want 9 1", first, ndone);
    end
    start = 1'b1; k_len = 16'd3;
    step();
    start = 1'b0;
    for (int c = 1; c < 7; c++) step();
    checks++;
    if (obs !== 7'b0111110) begin
      errors++; $display("FAIL drain_before_reset got %b want %b", obs, 7'b0111110);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b0000000) begin
      errors++; $display("FAIL async_reset got %b want %b", obs, 7'b0000000);
    end
    step(); step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b0000000) begin
      errors++; $display("FAIL reset_release_state got %b want %b", obs, 7'b0000000);
    end
    step();
    checks++;
    if (obs !== 7'b0000000) begin
      errors++; $display("FAIL idle_after_reset got %b want %b", obs, 7'b0000000);
    end
    act_valid = 1'b0;
  endtask

  task automatic test_single_lane();
    start1 = 1'b1; k_len1 = 16'd1; act_valid1 = 1'b1;
    step();
    start1 = 1'b0;
    #1;
    checks++;
    if (obs1 !== 7'b1111010) begin
      errors++; $display("FAIL single_lane_c1 got %b want %b", obs1, 7'b1111010);
    end
    step();
    checks++;
    if (obs1 !== 7'b0000011) begin
      errors++; $display("FAIL single_lane_c2 got %b want %b", obs1, 7'b0000011);
    end
    step();
    checks++;
    if (obs1 !== 7'b0000000) begin
      errors++; $display("FAIL single_lane_c3 got %b want %b", obs1, 7'b0000000);
    end
`ifdef SYSTOLIC_CTRL_PERF_EN
    checks++;
    if (tile_cyc1 !== 32'd2 || stall_cnt1 !== 32'd0) begin
      errors++; $display("FAIL single_lane_perf got tile=%0d stall=%0d want 2 0", tile_cyc1, stall_cnt1);
    end
`endif
    act_valid1 = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0; abort = 1'b0; act_valid = 1'b0; k_len = 16'd0;
    start1 = 1'b0; abort1 = 1'b0; act_valid1 = 1'b0; k_len1 = 16'd0;
    #1 rst_n = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_zero_len();
    test_abort();
    test_busy_start_reset();
    test_single_lane();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
